// File: rtl/umi_rr_arbiter_if.sv
// Bundles the requester-side and downstream-side signals of the round-robin arbiter.
// slave = arbiter view, master = requesters plus downstream sink.
interface umi_rr_arbiter_if #(
    parameter int N  = 4,
    parameter int DW = 256,
    parameter int SW = (N > 1) ? $clog2(N) : 1
);
    logic [N*DW-1:0] in_packet;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [N-1:0]    enable;
    logic [DW-1:0]   out_packet;
    logic            out_valid;
    logic            out_ready;
    logic [SW-1:0]   out_src;
    logic [SW-1:0]   grant_ptr;

    modport slave (
        input  in_packet, in_valid, enable, out_ready,
        output in_ready, out_packet, out_valid, out_src, grant_ptr
    );

    modport master (
        output in_packet, in_valid, enable, out_ready,
        input  in_ready, out_packet, out_valid, out_src, grant_ptr
    );
endinterface

// File: rtl/umi_rr_arbiter.sv
// Round-robin N:1 UMI packet arbiter feeding a single registered output stage.
// Latency: 1 cycle from accept to out_valid; one packet per cycle sustained.
// Backpressure: !out_ready with a held packet blocks all in_ready; draining reloads same edge.
module umi_rr_arbiter #(
    parameter int N  = 4,
    parameter int DW = 256,
    parameter int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            nreset,
    umi_rr_arbiter_if.slave bus
);
    logic [N-1:0]  req;
    logic          load;
    logic          found;
    logic [SW-1:0] sel;
    logic [DW-1:0] win_pkt;

    logic          out_valid_q;
    logic [DW-1:0] out_packet_q;
    logic [SW-1:0] out_src_q;
    logic [SW-1:0] grant_ptr_q;

    assign req  = bus.in_valid & bus.enable;
    // nreset gates load so no in_ready pulse can escape while reset is held
    assign load = nreset && (|req) && (!out_valid_q || bus.out_ready);

    always_comb begin : pick
        int idx;
        found   = 1'b0;
        sel     = '0;
        win_pkt = '0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(grant_ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found   = 1'b1;
                sel     = SW'(idx);
                win_pkt = bus.in_packet[idx*DW +: DW];
            end
        end
    end

    always_comb begin
        bus.in_ready = '0;
        for (int i = 0; i < N; i++) begin
            bus.in_ready[i] = load && (sel == SW'(i));
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            out_valid_q  <= 1'b0;
            out_packet_q <= '0;
            out_src_q    <= '0;
            grant_ptr_q  <= '0;
        end else if (load) begin
            out_valid_q  <= 1'b1;
            out_packet_q <= win_pkt;
            out_src_q    <= sel;
            grant_ptr_q  <= (int'(sel) == N - 1) ? '0 : sel + SW'(1);
        end else if (bus.out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_packet = out_packet_q;
    assign bus.out_src    = out_src_q;
    assign bus.grant_ptr  = grant_ptr_q;
endmodule

// File: tb/tb_umi_rr_arbiter.sv
// Randomized and directed bench for umi_rr_arbiter against a rotation-order reference model.
module tb_umi_rr_arbiter;
    localparam int N  = 4;
    localparam int DW = 256;
    localparam int SW = 2;

    logic clk;
    logic nreset;

    umi_rr_arbiter_if #(.N(N), .DW(DW), .SW(SW)) bus ();

    umi_rr_arbiter #(.N(N), .DW(DW), .SW(SW)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // upstream drive state
    logic [N-1:0]  vld;
    logic [N-1:0]  en;
    logic [DW-1:0] pkt [N];
    logic          ordy;

    // reference model state
    logic          m_ov;
    logic [DW-1:0] m_pkt;
    int            m_src;
    int            m_ptr;
    int            last_acc;

    int n_chk;
    int n_pass;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] rnd_pkt();
        logic [DW-1:0] p;
        for (int w = 0; w < DW / 32; w++) p[w*32 +: 32] = $urandom;
        return p;
    endfunction

    task automatic apply();
        bus.in_valid  = vld;
        bus.enable    = en;
        bus.out_ready = ordy;
        for (int i = 0; i < N; i++) bus.in_packet[i*DW +: DW] = pkt[i];
    endtask

    task automatic model_reset();
        m_ov  = 1'b0;
        m_pkt = '0;
        m_src = 0;
        m_ptr = 0;
    endtask

    // One clock: check in_ready before the edge, advance model, check registered outputs after it.
    task automatic step();
        int            win;
        logic          ld;
        logic [N-1:0]  exp_rdy;
        apply();
        #1;
        win = -1;
        for (int k = 0; k < N; k++) begin
            int p;
            p = (m_ptr + k) % N;
            if (win < 0 && vld[p] && en[p]) win = p;
        end
        ld      = nreset && (win >= 0) && (!m_ov || ordy);
        exp_rdy = '0;
        if (ld) exp_rdy[win] = 1'b1;
        chk("in_ready", DW'(bus.in_ready), DW'(exp_rdy));
        @(posedge clk);
        last_acc = ld ? win : -1;
        if (ld) begin
            m_ov  = 1'b1;
            m_pkt = pkt[win];
            m_src = win;
            m_ptr = (win + 1) % N;
        end else if (ordy) begin
            m_ov = 1'b0;
        end
        #1;
        chk("out_valid",  DW'(bus.out_valid), DW'(m_ov));
        chk("out_src",    DW'(bus.out_src),   DW'(m_src));
        chk("grant_ptr",  DW'(bus.grant_ptr), DW'(m_ptr));
        chk("out_packet", bus.out_packet,     m_pkt);
        @(negedge clk);
    endtask

    task automatic run(input int cycles);
        for (int c = 0; c < cycles; c++) step();
    endtask

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        last_acc = -1;
        nreset   = 1'b0;
        model_reset();
        vld  = '1;
        en   = '1;
        ordy = 1'b1;
        for (int i = 0; i < N; i++) pkt[i] = rnd_pkt();

        // reset held with every requester valid
        run(3);
        @(negedge clk);
        nreset = 1'b1;
        vld    = '0;
        run(4);

        // full contention, fixed per-port packets
        for (int i = 0; i < N; i++) pkt[i] = {8{32'(i + 1)}};
        vld = '1;
        run(8);

        // backpressure with two ports valid
        vld  = 4'b0101;
        ordy = 1'b0;
        for (int i = 0; i < N; i++) pkt[i] = rnd_pkt();
        run(6);
        ordy = 1'b1;
        run(3);

        // sparse traffic and pointer wrap
        vld = 4'b0100; run(1);
        vld = 4'b1000; run(1);
        vld = 4'b0010; run(1);
        vld = 4'b0000; run(3);

        // enable mask, then full enable
        vld = '1;
        en  = 4'b1010;
        run(6);
        en = 4'hF;
        run(6);

        // randomized traffic honouring the hold-until-ready contract
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 15) == 0) en = 4'($urandom);
            ordy = ($urandom_range(0, 3) != 0);
            step();
            for (int i = 0; i < N; i++) begin
                if (!vld[i] || last_acc == i) begin
                    vld[i] = ($urandom_range(0, 2) != 0);
                    pkt[i] = rnd_pkt();
                end
            end
        end

        // reset between edges while a packet is held
        en   = '1;
        vld  = 4'b0001;
        ordy = 1'b0;
        pkt[0] = rnd_pkt();
        run(2);
        #2;
        nreset = 1'b0;
        #1;
        chk("rst_async_out_valid", DW'(bus.out_valid), DW'(1'b0));
        chk("rst_async_in_ready",  DW'(bus.in_ready),  DW'(0));
        chk("rst_async_out_packet", bus.out_packet,    '0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        nreset = 1'b1;
        vld    = '0;
        ordy   = 1'b1;
        run(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/umi_rr_arbiter.md
Name: umi_rr_arbiter

Overview:
- Shares one UMI TX port (a packet sink such as a umi_tx_sim instance) between N packet requesters, e.g. several umi_rx_sim-fed processing lanes.
- Arbitration is round-robin across enabled requesters.
- The winning packet goes into a single output register, giving a registered valid/ready interface downstream at full throughput (one packet per cycle).
- Reports the source index of each forwarded packet so downstream logic or a bench can check ordering.

Parameters:
- N, 4, number of requester ports (1..16)
- DW, 256, UMI packet width in bits
- SW, $clog2(N) (min 1), width of the source index

Ports:
- clk  input  1  clock
- nreset  input  1  asynchronous active-low reset
- in_packet  input  N*DW  requester packets, port i at [i*DW +: DW]
- in_valid  input  N  per-port packet valid
- in_ready  output  N  per-port accept; at most one bit high per cycle
- enable  input  N  per-port arbitration enable mask (quasi-static)
- out_packet  output  DW  registered winning packet
- out_valid  output  1  output register holds a packet
- out_ready  input  1  downstream accepts out_packet
- out_src  output  SW  index of the port that supplied out_packet
- grant_ptr  output  SW  current round-robin pointer (debug)

Behaviour:
- Reset: asynchronous on nreset low. Clears out_valid=0, out_packet=0, out_src=0 and grant_ptr=0. in_ready is all zero while in reset.
- Reset mid-operation: any packet held in the output register is discarded. No in_ready pulse occurs during reset.
- Request vector: req = in_valid & enable.
- Load condition: load = |req && (!out_valid || out_ready). The output register is free or being drained this cycle, so back-to-back packets flow with no bubble.
- Selection (combinational): sel is the first set bit of req searching grant_ptr, grant_ptr+1, …, N-1, 0, …, grant_ptr-1 (wrap-around).
- in_ready[i] = load && (i == sel). All other bits are 0. When load=0, in_ready is all zero.
- On a load cycle (registered):
  - out_packet <= in_packet[sel]
  - out_src <= sel
  - out_valid <= 1
  - grant_ptr <= (sel == N-1) ? 0 : sel+1
- Drain without reload: out_valid && out_ready && !load gives out_valid <= 0. out_packet and out_src keep their last values.
- Stall: out_valid && !out_ready gives load=0. out_packet, out_src and grant_ptr are stable; no in_ready asserted.
- grant_ptr changes only on load. An idle cycle does not move it.
- Latency: a packet accepted at edge k appears on out_packet/out_valid after edge k. This is a minimum of 1 cycle from in_valid to out_valid.
- Fairness: with every enabled port continuously valid, each enabled port is granted exactly once per rotation of the enabled ports. No port waits more than N-1 grants.
- Disabled ports: enable[i]=0 removes port i from arbitration. Its in_valid is ignored and in_ready[i] stays 0. Its packet stays pending upstream until re-enabled. Changing enable takes effect in the same cycle's arbitration.
- N=1: grant_ptr is constant 0. The block degenerates to a single registered pipeline stage with an enable gate.
- Upstream contract: in_valid[i] with its packet holds until in_ready[i]. The arbiter has no internal packet storage beyond the single output register.
- Packet contents pass through unmodified. There is no width conversion.

Test Plan:
- Reset/idle: hold nreset=0 with all in_valid=1. Require out_valid=0, in_ready=0 and grant_ptr=0. Release reset with all in_valid=0: outputs stay 0 and grant_ptr=0 indefinitely.
- Full contention: N=4, all in_valid=1, enable=4'hF, out_ready=1, each port's packet = {8{32'h(i+1)}}, 8 cycles.
  - out_src sequence is 0,1,2,3,0,1,2,3 with out_valid high every cycle after the first.
  - Each in_ready bit is one-hot in turn.
- Backpressure: 2 ports valid, out_ready=0 for 5 cycles.
  - The first packet is loaded, then in_ready=0 and out_packet is stable for 5 cycles.
  - When out_ready=1, the next port is forwarded on the same edge that drains the first.
- Sparse/wrap: only port 3 valid, grant_ptr=3.
  - Port 3 is granted and grant_ptr wraps to 0.
  - Then only port 1 is valid: granted and grant_ptr=2.
  - Idle cycles leave grant_ptr unchanged.
- Enable mask: all valid, enable=4'b1010.
  - out_src alternates 1,3,1,3 and in_ready[0], in_ready[2] are never asserted.
  - Setting enable=4'hF resumes rotation from the current grant_ptr.
- Reset mid-transfer: out_valid=1 with out_ready=0, then assert nreset=0 asynchronously between edges.
  - out_valid drops immediately and the held packet never appears after reset release.
